// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: streams sequential fetches from an instruction ROM
// into a small buffer and presents the head to decode with a valid/ready handshake.
// A redirect flushes the buffer and restarts fetching from the new target.
// Optional feature macro IFU_STAT_EN adds the fetch_cnt port (accepted handshakes).
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
`ifdef IFU_STAT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_REDIR} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic               infl_q, infl_d;
    logic [31:0]        infl_addr_q, infl_addr_d;
    logic [31:0]        fifo_inst_q [DEPTH];
    logic [31:0]        fifo_pc_q   [DEPTH];

    logic               jump;
    logic               pop;
    logic               push;
    logic [CNT_W:0]     occ;

    // Redirects are only honoured once the unit has left idle.
    assign jump = jump_en && (state_q != S_IDLE);
    assign pop  = if_valid && if_ready;
    // A response arriving in a redirect cycle belongs to the old stream.
    assign push = infl_q && !jump;
    assign occ  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, infl_q};

    // Output decode: request gating on occupancy, head of buffer to decode.
    always_comb begin
        rom_req  = 1'b0;
        if (state_q == S_FETCH && !jump) begin
            rom_req = (occ < DEPTH_C) || ((occ == DEPTH_C) && pop);
        end
        rom_addr = pc_q;
        if_valid = (cnt_q != '0) && (state_q != S_REDIR);
        if_inst  = fifo_inst_q[rd_q];
        if_pc    = fifo_pc_q[rd_q];
    end

    // Next-state: FSM, fetch PC, buffer pointers/count and in-flight tracking.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        infl_d      = rom_req;
        infl_addr_d = rom_req ? pc_q : infl_addr_q;

        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (jump) state_d = S_REDIR;
            S_REDIR: state_d = jump ? S_REDIR : S_FETCH;
            default: state_d = S_IDLE;
        endcase

        if (rom_req) begin
            pc_d = pc_q + 32'd4;
        end

        if (jump) begin
            pc_d  = jump_addr & 32'hFFFF_FFFC;
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_W'(1);
            if (pop)  rd_d = rd_q + PTR_W'(1);
            if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
            if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            cnt_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            infl_q      <= 1'b0;
            infl_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            infl_q      <= infl_d;
            infl_addr_q <= infl_addr_d;
        end
    end

    // Buffer storage; reset contents give the NOP/RESET_PC head values in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst_q[i] <= NOP;
                fifo_pc_q[i]   <= RESET_PC;
            end
        end else if (push) begin
            fifo_inst_q[wr_q] <= rom_data;
            fifo_pc_q[wr_q]   <= infl_addr_q;
        end
    end

`ifdef IFU_STAT_EN
    logic [31:0] stat_q;

    // Count accepted handshakes, including one coinciding with a redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= '0;
        end else if (pop) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign fetch_cnt = stat_q;
`endif

endmodule
